// File: rtl/niosqs_pio_in.sv
// niosqs_pio_in: Avalon-MM input PIO with a two-flop pin synchroniser, per-bit edge capture and one IRQ.
// Optional PIO_IN_BIT_CLEAR_EN: EDGE writes become write-1-to-clear instead of clearing every bit.

module niosqs_pio_in_bit #(
    parameter int EDGE_TYPE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    input  logic clr,
    output logic data_in,
    output logic edge_cap
);
    logic s1, s2, s3, detect;

    always_comb begin
        case (EDGE_TYPE)
            0:       detect = s2 & ~s3;
            1:       detect = ~s2 & s3;
            default: detect = s2 ^ s3;
        endcase
    end

    // A detected edge wins over a simultaneous clear so no event is ever dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            edge_cap <= 1'b0;
        end else begin
            s1       <= pin;
            s2       <= s1;
            s3       <= s2;
            edge_cap <= detect | (edge_cap & ~clr);
        end
    end

    assign data_in = s2;
endmodule

module niosqs_pio_in #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0,
    parameter int IRQ_TYPE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    typedef struct packed {
        logic mask_wr;
        logic edge_wr;
    } wr_sel_t;

    wr_sel_t          wr_sel;
    logic [WIDTH-1:0] data_in, edge_capture, irq_mask, edge_clr;
    logic [31:0]      rd_mux;
    logic             wr_strobe;
    logic             unused_wdata;

    assign wr_strobe      = chipselect & ~write_n;
    assign wr_sel.mask_wr = wr_strobe & (address == 3'd2);
    assign wr_sel.edge_wr = wr_strobe & (address == 3'd3);
    assign unused_wdata   = ^writedata;

`ifdef PIO_IN_BIT_CLEAR_EN
    assign edge_clr = wr_sel.edge_wr ? writedata[WIDTH-1:0] : '0;
`else
    assign edge_clr = {WIDTH{wr_sel.edge_wr}};
`endif

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            niosqs_pio_in_bit #(.EDGE_TYPE(EDGE_TYPE)) u_bit (
                .clk      (clk),
                .reset    (reset),
                .pin      (in_port[i]),
                .clr      (edge_clr[i]),
                .data_in  (data_in[i]),
                .edge_cap (edge_capture[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)               irq_mask <= '0;
        else if (wr_sel.mask_wr) irq_mask <= writedata[WIDTH-1:0];
    end

    // Reads need no chipselect and have no side effects; upper bits stay zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux[WIDTH-1:0] = data_in;
            3'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            3'd3:    rd_mux[WIDTH-1:0] = edge_capture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_mux;
    end

    generate
        if (IRQ_TYPE == 1) begin : g_irq_edge
            assign irq = |(edge_capture & irq_mask);
        end else begin : g_irq_level
            assign irq = |(data_in & irq_mask);
        end
    endgenerate
endmodule

// File: tb/tb_niosqs_pio_in.sv
// Bench for niosqs_pio_in (WIDTH=8, rising edge, edge IRQ): vector table, corner sequences, random vs model.
module tb_niosqs_pio_in;
    localparam int W = 8;

`ifdef PIO_IN_BIT_CLEAR_EN
    localparam logic [31:0] BC_EXP = 32'h04;
    localparam bit BIT_CLEAR = 1'b1;
`else
    localparam logic [31:0] BC_EXP = 32'h00;
    localparam bit BIT_CLEAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
    logic [2:0]    address = '0;
    logic [31:0]   writedata = '0, readdata;
    logic [W-1:0]  in_port = '0;
    logic          irq;

    always #5 clk = ~clk;

    niosqs_pio_in #(.WIDTH(W), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    int checks = 0, failures = 0;

    // Model: pin history (index k = value sampled k edges ago), mask, captured edges, read register.
    logic [W-1:0] hist [3];
    logic [W-1:0] m_mask, m_edge;
    logic [31:0]  m_rd;

    function automatic bit m_irq();
        return |(m_edge & m_mask);
    endfunction

    task automatic model_step();
        logic [W-1:0] rise, clr;
        bit wr;
        if (reset) begin
            foreach (hist[k]) hist[k] = '0;
            m_mask = '0; m_edge = '0; m_rd = '0;
        end else begin
            wr = chipselect && !write_n;
            case (address)
                3'd0:    m_rd = 32'(hist[1]);
                3'd2:    m_rd = 32'(m_mask);
                3'd3:    m_rd = 32'(m_edge);
                default: m_rd = 32'h0;
            endcase
            rise = hist[1] & ~hist[2];
            if (wr && address == 3'd3) clr = BIT_CLEAR ? writedata[W-1:0] : {W{1'b1}};
            else                       clr = '0;
            m_edge = rise | (m_edge & ~clr);
            if (wr && address == 3'd2) m_mask = writedata[W-1:0];
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = in_port;
        end
    endtask

    task automatic drive(input bit rst, input bit cs, input bit wn, input logic [2:0] a,
                         input logic [31:0] wd, input logic [W-1:0] p);
        @(negedge clk);
        reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd; in_port = p;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Read helper (chipselect low) and write helper.
    task automatic rd(input logic [2:0] a, input logic [W-1:0] p);
        drive(1'b0, 1'b0, 1'b1, a, 32'h0, p);
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [W-1:0] p);
        drive(1'b0, 1'b1, 1'b0, a, wd, p);
    endtask

    typedef struct {
        bit           wr;
        logic [2:0]   addr;
        logic [31:0]  wd;
        logic [W-1:0] pins;
        logic [31:0]  exp_rd;
        bit           exp_irq;
    } vec_t;

    function automatic vec_t mk(bit w, logic [2:0] a, logic [31:0] wd, logic [W-1:0] p,
                                logic [31:0] er, bit ei);
        vec_t t;
        t.wr = w; t.addr = a; t.wd = wd; t.pins = p; t.exp_rd = er; t.exp_irq = ei;
        return t;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [W-1:0] pins;

        // Reset state
        drive(1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 8'h00);
        check("reset_rd", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);

        // Idle at every address, writes to DATA/unmapped ignored
        tbl.push_back(mk(0, 3'd0, 32'h0, 8'h00, 32'h0, 0));
        tbl.push_back(mk(0, 3'd1, 32'h0, 8'h00, 32'h0, 0));
        tbl.push_back(mk(0, 3'd2, 32'h0, 8'h00, 32'h0, 0));
        tbl.push_back(mk(0, 3'd3, 32'h0, 8'h00, 32'h0, 0));
        tbl.push_back(mk(0, 3'd4, 32'h0, 8'h00, 32'h0, 0));
        tbl.push_back(mk(1, 3'd7, 32'hFFFF_FFFF, 8'h00, 32'h0, 0));
        tbl.push_back(mk(1, 3'd0, 32'h0000_00FF, 8'h00, 32'h0, 0));
        // 0x00 -> 0xA5: DATA visible on the third edge, EDGE captures 0xA5
        tbl.push_back(mk(0, 3'd0, 32'h0, 8'hA5, 32'h0, 0));
        tbl.push_back(mk(0, 3'd0, 32'h0, 8'hA5, 32'h0, 0));
        tbl.push_back(mk(0, 3'd0, 32'h0, 8'hA5, 32'hA5, 0));
        tbl.push_back(mk(0, 3'd3, 32'h0, 8'hA5, 32'hA5, 0));
        // MASK=1 (upper writedata ignored), then clear EDGE
        tbl.push_back(mk(1, 3'd2, 32'hFFFF_FF01, 8'hA5, 32'h0, 1));
        tbl.push_back(mk(0, 3'd2, 32'h0, 8'hA5, 32'h01, 1));
        tbl.push_back(mk(1, 3'd3, 32'h0000_00FF, 8'hA5, 32'hA5, 0));
        // Falling on bit0 is not captured, the following rise raises irq at E2
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 3'd3, 32'h0, 8'hA4, 32'h0, 0));
        for (int k = 0; k < 2; k++) tbl.push_back(mk(0, 3'd3, 32'h0, 8'hA5, 32'h0, 0));
        tbl.push_back(mk(0, 3'd3, 32'h0, 8'hA5, 32'h0, 1));
        tbl.push_back(mk(0, 3'd3, 32'h0, 8'hA5, 32'h01, 1));
        tbl.push_back(mk(1, 3'd3, 32'h0000_00FF, 8'hA5, 32'h01, 0));
        // EDGE=0x05 then write 0x01 to EDGE
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 3'd3, 32'h0, 8'h00, 32'h0, 0));
        for (int k = 0; k < 2; k++) tbl.push_back(mk(0, 3'd3, 32'h0, 8'h05, 32'h0, 0));
        tbl.push_back(mk(0, 3'd3, 32'h0, 8'h05, 32'h0, 1));
        tbl.push_back(mk(0, 3'd3, 32'h0, 8'h05, 32'h05, 1));
        tbl.push_back(mk(1, 3'd3, 32'h0000_0001, 8'h05, 32'h05, 0));
        tbl.push_back(mk(0, 3'd3, 32'h0, 8'h05, BC_EXP, 0));

        foreach (tbl[k]) begin
            drive(1'b0, tbl[k].wr, !tbl[k].wr, tbl[k].addr, tbl[k].wd, tbl[k].pins);
            check($sformatf("vec%0d_rd", k), readdata, tbl[k].exp_rd);
            check($sformatf("vec%0d_irq", k), {31'b0, irq}, {31'b0, tbl[k].exp_irq});
        end

        // Rise on bit2 lands in the same cycle as a clear-all write: bit2 survives
        wr(3'd3, 32'hFF, 8'h01);
        check("setclr_pre_rd", readdata, BC_EXP);
        rd(3'd3, 8'h01); rd(3'd3, 8'h01);
        rd(3'd3, 8'h05); rd(3'd3, 8'h05);
        wr(3'd3, 32'hFF, 8'h05);
        check("setclr_wr_rd", readdata, 32'h0);
        rd(3'd3, 8'h05);
        check("setclr_edge", readdata, 32'h04);

        // Reset in the middle of a MASK write with EDGE=0xFF
        rd(3'd3, 8'h00); rd(3'd3, 8'h00); rd(3'd3, 8'h00);
        rd(3'd3, 8'hFF); rd(3'd3, 8'hFF); rd(3'd3, 8'hFF);
        rd(3'd3, 8'hFF);
        check("pre_rst_edge", readdata, 32'hFF);
        wr(3'd2, 32'hFF, 8'hFF);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h0F, 8'hFF);
        check("rst_rd", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rd(3'd2, 8'hFF);
        check("post_rst_mask", readdata, 32'h0);
        rd(3'd3, 8'hFF);
        check("post_rst_edge", readdata, 32'h0);
        rd(3'd3, 8'hFF);
        check("post_rst_edge2", readdata, 32'h0);
        rd(3'd3, 8'hFF);
        check("post_rst_rise", readdata, 32'hFF);

        // Randomised traffic against the model
        pins = 8'hFF;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) pins = W'($urandom);
            drive($urandom_range(0, 63) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
                  3'($urandom), $urandom, pins);
            check("rand_rd", readdata, m_rd);
            check("rand_irq", {31'b0, irq}, {31'b0, m_irq()});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
